// File: rtl/crc9_enc_seq_pkg.sv
// Shared constants and FSM encoding for the CRC-9 divider sequencer.
package crc9_enc_seq_pkg;

  localparam int P_W   = 9;
  localparam int CNT_W = 11;

  // x^9 + x^4 + 1, leading term implied
  localparam logic [P_W-1:0] CRC9_POLY = 9'h011;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUT     = 3'd4
  } state_e;

endpackage

// File: rtl/crc9_enc_seq_cnt.sv
// Shift-cycle counter: synchronous clear, count enable, terminal flag at N-1.
module crc9_enc_seq_cnt
  import crc9_enc_seq_pkg::*;
#(
  parameter int N = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 11'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(N - 1));

endmodule

// File: rtl/crc9_enc_seq.sv
// Sequencer around the 9-bit parity divider: clear, N shift strobes, capture
// the remainder and present {message, parity, zero, err} downstream.
module crc9_enc_seq
  import crc9_enc_seq_pkg::*;
#(
  parameter int N = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             div_clr,
  output logic             div_shift,
  output logic [N-1:0]     div_data,
  input  logic [CNT_W-1:0] div_count,
  input  logic [P_W-1:0]   div_rem,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [P_W-1:0]   out_parity,
  output logic             out_zero,
  output logic             out_err
);

  state_e           state_q;
  logic             in_ready_q;
  logic             div_clr_q;
  logic             div_shift_q;
  logic [N-1:0]     msg_q;
  logic             out_valid_q;
  logic [N-1:0]     out_data_q;
  logic [P_W-1:0]   out_parity_q;
  logic             out_zero_q;
  logic             out_err_q;
  logic             cnt_tc_s;

  crc9_enc_seq_cnt #(.N(N)) u_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (state_q == ST_CLEAR),
    .en_i  (state_q == ST_SHIFT),
    .tc_o  (cnt_tc_s)
  );

  // Strobes are set one state ahead so div_clr/div_shift come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b0;
      div_clr_q    <= 1'b1;
      div_shift_q  <= 1'b0;
      msg_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_parity_q <= '0;
      out_zero_q   <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          div_clr_q <= 1'b0;
          if (in_valid && in_ready_q) begin
            msg_q      <= in_data;
            in_ready_q <= 1'b0;
            div_clr_q  <= 1'b1;
            state_q    <= ST_CLEAR;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          div_clr_q   <= 1'b0;
          div_shift_q <= 1'b1;
          state_q     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cnt_tc_s) begin
            div_shift_q <= 1'b0;
            state_q     <= ST_CAPTURE;
          end else begin
            div_shift_q <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          out_data_q   <= msg_q;
          out_parity_q <= div_rem;
          out_zero_q   <= (div_rem == 9'h000);
          out_err_q    <= (div_count != CNT_W'(N));
          out_valid_q  <= 1'b1;
          state_q      <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b0;
          div_clr_q   <= 1'b1;
          div_shift_q <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign div_clr    = div_clr_q;
  assign div_shift  = div_shift_q;
  assign div_data   = msg_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_parity = out_parity_q;
  assign out_zero   = out_zero_q;
  assign out_err    = out_err_q;

endmodule
